// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: default bit divisor and framing states.
package uart_rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 10416;
    localparam int unsigned ADDR_W_DEF       = 10;
    localparam int unsigned DATA_W           = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on dout whenever vld is high.
module uart_rx_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic             full_c
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [PTR_W-1:0] wadd;
    logic [PTR_W-1:0] radd;
    logic [PTR_W-1:0] wadd_nxt;
    logic [PTR_W-1:0] radd_nxt;
    logic             pop_ok;
    logic             push_ok;

    // One extra pointer bit distinguishes full from empty when the low bits match.
    assign full_c   = (wadd[ADDR_W] != radd[ADDR_W]) &&
                      (wadd[ADDR_W-1:0] == radd[ADDR_W-1:0]);
    assign pop_ok   = pop && vld;
    assign push_ok  = push && (!full_c || pop_ok);
    assign wadd_nxt = wadd + PTR_W'(push_ok);
    assign radd_nxt = radd + PTR_W'(pop_ok);
    assign dout     = ram[radd[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wadd <= '0;
            radd <= '0;
            vld  <= 1'b0;
        end else begin
            wadd <= wadd_nxt;
            radd <= radd_nxt;
            vld  <= (wadd_nxt != radd_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            ram[wadd[ADDR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, frames bytes with mid-bit sampling and
// queues good bytes in a show-ahead FIFO drained through vdout/rd.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] dout,
    output logic              vdout,
    input  logic              rd,
    output logic              frame_err,
    output logic              overflow
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]        sync;
    logic              rxs;
    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              push_c;
    logic              pop_c;
    logic              full_c;

    assign rxs    = sync[1];
    assign push_c = (state == STOP) && (cnt == CNT_LAST) && rxs;
    assign pop_c  = rd && vdout;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a stuck-low line cannot re-trigger.
                    cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_c && full_c && !pop_c) begin
            overflow <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (clk_100MHz),
        .reset  (reset),
        .push   (push_c),
        .din    (shreg),
        .pop    (rd),
        .dout   (dout),
        .vld    (vdout),
        .full_c (full_c)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx against a queue-based model of the receive path.
module tb_uart_rx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rd;
    logic [7:0] dout;
    logic       vdout;
    logic       frame_err;
    logic       overflow;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          fe_cnt = 0;
    int          fe_m   = 0;
    byte unsigned q[$];
    bit          ovf_m  = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .rxd        (rxd),
        .dout       (dout),
        .vdout      (vdout),
        .rd         (rd),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        rxd   = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        @(negedge clk_100MHz);
    endtask

    // Drives one frame; stop sample lands 10.5 cycles into the stop bit.
    task automatic send_frame(input byte unsigned b, input bit stop, input bit chk_lat, input bit pop_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rxd = bits[i];
            repeat (CPB) @(negedge clk_100MHz);
        end
        rxd = stop;
        repeat (10) @(negedge clk_100MHz);
        if (chk_lat) chk("vdout_before_stop", 32'(vdout), 32'(q.size() != 0));
        if (pop_at) begin
            chk("dout_at_stop", 32'(dout), 32'(q[0]));
            rd = 1'b1;
        end
        @(negedge clk_100MHz);
        rd = 1'b0;
        if (pop_at) void'(q.pop_front());
        if (stop) begin
            if (q.size() < DEPTH) q.push_back(b);
            else ovf_m = 1'b1;
        end else begin
            fe_m++;
        end
        if (chk_lat) chk("vdout_after_stop", 32'(vdout), 32'(q.size() != 0));
        repeat (CPB - 11) @(negedge clk_100MHz);
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            chk("vdout_pop", 32'(vdout), 32'(1));
            chk("dout_pop", 32'(dout), 32'(q[0]));
            rd = 1'b1;
            @(negedge clk_100MHz);
            rd = 1'b0;
            void'(q.pop_front());
        end
    endtask

    task automatic drain();
        pop_n(q.size());
        chk("vdout_empty", 32'(vdout), 32'(0));
    endtask

    initial begin
        byte unsigned rb;
        bit           rs;
        rxd   = 1'b1;
        rd    = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        chk("reset_vdout", 32'(vdout), 32'(0));
        chk("reset_frame_err", 32'(frame_err), 32'(0));
        chk("reset_overflow", 32'(overflow), 32'(0));
        idle(5);

        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        chk("single_dout", 32'(dout), 32'h55);
        drain();

        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        drain();
        chk("b2b_frame_err", 32'(fe_cnt), 32'(fe_m));

        rxd = 1'b0;
        repeat (5) @(negedge clk_100MHz);
        idle(40);
        chk("glitch_vdout", 32'(vdout), 32'(0));
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        drain();

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge clk_100MHz);
        idle(20);
        chk("ferr_count", 32'(fe_cnt), 32'(1));
        chk("ferr_vdout", 32'(vdout), 32'(0));
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        drain();
        chk("ferr_count_after", 32'(fe_cnt), 32'(1));

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'(1));
        drain();
        chk("ovf_sticky", 32'(overflow), 32'(1));

        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'(0));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h05, 1'b1, 1'b0, 1'b1);
        chk("full_pushpop_ovf", 32'(overflow), 32'(0));
        drain();

        rb = 8'h9E;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk_100MHz);
        for (int i = 0; i < 4; i++) begin
            rxd = rb[i];
            repeat (CPB) @(negedge clk_100MHz);
        end
        do_reset();
        chk("midrst_wadd", 32'(dut.u_fifo.wadd), 32'(0));
        chk("midrst_radd", 32'(dut.u_fifo.radd), 32'(0));
        chk("midrst_vdout", 32'(vdout), 32'(0));
        idle(20);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0);
        drain();

        for (int it = 0; it < 30; it++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, 1'b0, 1'b0);
            if (!rs) begin
                rxd = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk_100MHz);
                idle($urandom_range(4, 12));
            end else begin
                idle($urandom_range(0, 10));
            end
            pop_n($urandom_range(0, q.size()));
            chk("rand_frame_err", 32'(fe_cnt), 32'(fe_m));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive counterpart to the core's existing transmit UART.
- Line rate is 9600 baud from clk_100MHz by default.
- Serial input is synchronised, start bits are validated, each bit is sampled at mid-bit, and the stop bit is checked.
- Good bytes are pushed into an internal 1024-entry FIFO. The core drains the FIFO through a valid/pop interface.

Parameters:
- CLKS_PER_BIT, 10416, clk_100MHz cycles per bit (100 MHz / 9600, same divisor as TX).
- ADDR_W, 10, FIFO address width; depth = 2**ADDR_W.

Ports:
- clk_100MHz  input  1  system clock.
- reset  input  1  synchronous, active-high reset (clock clk_100MHz).
- rxd  input  1  asynchronous serial line; idles high.
- dout  output  8  byte at FIFO head; valid only while vdout=1.
- vdout  output  1  FIFO non-empty.
- rd  input  1  pop head byte; ignored when vdout=0.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overflow  output  1  sticky; set when a good byte arrives with the FIFO full.

Behaviour:
- **Reset values**
  - Synchroniser flops = 1; state = IDLE; bit/clk counters = 0.
  - wadd = radd = 0; vdout = 0; frame_err = 0; overflow = 0.
  - dout is don't-care.
  - Reset aborts any frame in progress; no partial byte is ever pushed.
- **Synchroniser:** 2-FF synchroniser on rxd gives rxs. All decisions use rxs only, so latency is 2 cycles.
- **State machine** (one sample per CLKS_PER_BIT cycles; clk counter restarts on every state change):
  - IDLE: rxs==0 → START, counter=0.
  - START: when counter==CLKS_PER_BIT/2-1, sample rxs.
    - 1 → IDLE (glitch rejected, no error).
    - 0 → DATA, bit index=0.
  - DATA: when counter==CLKS_PER_BIT-1, shift rxs in LSB-first. After bit 7 → STOP.
  - STOP: when counter==CLKS_PER_BIT-1, sample rxs.
    - 1: push byte → IDLE.
    - 0: pulse frame_err, discard byte → BREAK.
  - BREAK: wait for rxs==1 → IDLE. This prevents a held-low line from re-triggering.
  - Returning to IDLE at mid-stop-bit allows back-to-back frames with a single stop bit.
- **FIFO**
  - Push writes ram[wadd] and increments wadd on the cycle the stop sample is accepted.
  - vdout is high from the next cycle.
  - Occupancy uses ADDR_W+1-bit pointers:
    - empty = pointers equal.
    - full = MSBs differ and low bits are equal.
  - dout = ram[radd[ADDR_W-1:0]] (show-ahead).
  - rd && vdout increments radd; the next entry appears on the following cycle.
  - Push and pop in the same cycle are both honoured, occupancy unchanged, including when full.
  - Push when full and no pop: byte dropped, overflow set; overflow clears only on reset.
  - Pointers wrap naturally at 2**(ADDR_W+1).
- **Arithmetic:** clk counter is $clog2(CLKS_PER_BIT) bits; bit index is 3 bits.

Decomposition:
- Shared package/header: CLKS_PER_BIT default, state encodings IDLE=0, START=1, DATA=2, STOP=3, BREAK=4.
- One natural sub-module: uart_rx_fifo (show-ahead sync FIFO with push/pop/full/empty), reusable for the TX side.
- Framing FSM and synchroniser stay in uart_rx.

Test Plan (CLKS_PER_BIT=16 for sim):
- **Single byte:** drive 0x55 as 8N1 at 16 clk/bit → vdout rises 1 cycle after the stop sample, dout=0x55; rd pulse → vdout=0.
- **Back-to-back:** 0xA3, 0x00, 0xFF with no idle gap → FIFO pops A3, 00, FF in order; frame_err never pulses.
- **Glitch:** rxd low for 5 cycles then high → no push, state back in IDLE, vdout=0.
- **Framing error:** 0x3C with stop bit low, held low 40 cycles, then high, then 0x12 → one frame_err pulse, 0x3C not stored, 0x12 received.
- **Overflow with ADDR_W=2:** send 5 bytes 0x01..0x05 without rd → overflow=1; contents 01..04; pop count 4, then vdout=0.
- **Reset mid-frame:** assert reset after data bit 3 of 0x9E → nothing pushed, pointers 0, next frame 0x47 received correctly.
